// File: rtl/score_display.sv
// Two-score, time-multiplexed 7-segment driver for a common-anode display.
// A free-running refresh counter chooses between the two scores. Segments and digit selects are active-low.
module score_display #(
    parameter int CNT_WIDTH = 21,
    parameter int SEL_BIT   = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] scor1,
    input  logic [3:0] scor2,
    output logic [7:0] out,
    output logic [3:0] dec
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [7:0]           out_q, out_d;
    logic [3:0]           dec_q, dec_d;
    logic                 sel;

    // BCD value to active-low segments {dp, g..a}. Non-BCD inputs show a distinct error glyph.
    function automatic logic [7:0] seg_decode(input logic [3:0] value);
        logic [7:0] pattern;
        case (value)
            4'd0:    pattern = 8'hC0;
            4'd1:    pattern = 8'hF9;
            4'd2:    pattern = 8'hA4;
            4'd3:    pattern = 8'hB0;
            4'd4:    pattern = 8'h99;
            4'd5:    pattern = 8'h92;
            4'd6:    pattern = 8'h82;
            4'd7:    pattern = 8'hF8;
            4'd8:    pattern = 8'h80;
            4'd9:    pattern = 8'h90;
            default: pattern = 8'h0A;
        endcase
        return pattern;
    endfunction

    assign sel = count_q[SEL_BIT];

    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
        out_d = sel ? seg_decode(scor2) : seg_decode(scor1);
        // Score 1 is shown on digit 1 and score 2 on digit 3. All digits are dark while the display is disabled.
        if (!enable) begin
            dec_d = 4'b1111;
        end else if (sel) begin
            dec_d = 4'b0111;
        end else begin
            dec_d = 4'b1101;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            out_q   <= 8'hFF;
            dec_q   <= 4'b1111;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
            dec_q   <= dec_d;
        end
    end

    assign out = out_q;
    assign dec = dec_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a small counter (CNT_WIDTH=4, SEL_BIT=2).
// Expected segment and digit values are hand-derived.
module tb_score_display;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] scor1;
    logic [3:0] scor2;
    logic [7:0] out;
    logic [3:0] dec;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] seg_tbl [16];

    score_display #(
        .CNT_WIDTH(4),
        .SEL_BIT  (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .scor1 (scor1),
        .scor2 (scor2),
        .out   (out),
        .dec   (dec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [7:0] exp_out, input logic [3:0] exp_dec);
        chk({tag, ".out"}, out, exp_out);
        chk({tag, ".dec"}, {4'h0, dec}, {4'h0, exp_dec});
    endtask

    task automatic edge_sample();
        @(posedge clock);
        #1;
    endtask

    initial begin
        seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A};

        // Reset state
        reset = 1'b1; enable = 1'b0; scor1 = 4'd0; scor2 = 4'd0;
        repeat (2) @(posedge clock);
        #2;
        chk_both("reset_hold", 8'hFF, 4'b1111);

        // First edge after release shows score 1
        @(negedge clock);
        reset = 1'b0; enable = 1'b1; scor1 = 4'd3; scor2 = 4'd7;
        edge_sample();
        $display("txn first_edge out=%h dec=%b", out, dec);
        chk_both("first_edge", 8'hB0, 4'b1101);
        edge_sample();
        edge_sample();

        // Asynchronous reset: assert it mid-cycle and check without any clock edge in between
        #2;
        reset = 1'b1;
        #1;
        $display("txn async_reset out=%h dec=%b", out, dec);
        chk_both("async_reset", 8'hFF, 4'b1111);
        @(negedge clock);
        reset = 1'b0;

        // Multiplexing: edge k samples count k-1; bit 2 selects the score; the counter wraps after edge 16
        for (int k = 1; k <= 20; k++) begin
            edge_sample();
            $display("txn mux_edge%0d out=%h dec=%b", k, out, dec);
            if ((((k - 1) / 4) % 2) == 1) begin
                chk_both($sformatf("mux_edge%0d", k), 8'hF8, 4'b0111);
            end else begin
                chk_both($sformatf("mux_edge%0d", k), 8'hB0, 4'b1101);
            end
        end

        // Decode sweep: the counter is frozen at 0, so sel stays 0 and the digits are blanked
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; enable = 1'b0;
        for (int v = 0; v < 16; v++) begin
            @(negedge clock);
            scor1 = 4'(v);
            edge_sample();
            $display("txn decode_%0d out=%h dec=%b", v, out, dec);
            chk_both($sformatf("decode_%0d", v), seg_tbl[v], 4'b1111);
        end

        // Enable gating: count is 0; run six edges so the last one samples count 5 (score-2 phase)
        @(negedge clock);
        enable = 1'b1; scor1 = 4'd3; scor2 = 4'd4;
        repeat (6) edge_sample();
        chk_both("gate_pre", 8'h99, 4'b0111);
        @(negedge clock);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            edge_sample();
            $display("txn gate_off%0d out=%h dec=%b", k, out, dec);
            chk_both($sformatf("gate_off%0d", k), 8'h99, 4'b1111);
        end
        // The count was frozen at 6, so two score-2 edges remain before score 1 returns
        @(negedge clock);
        enable = 1'b1;
        edge_sample();
        chk_both("resume_6", 8'h99, 4'b0111);
        edge_sample();
        chk_both("resume_7", 8'h99, 4'b0111);
        edge_sample();
        $display("txn resume_8 out=%h dec=%b", out, dec);
        chk_both("resume_8", 8'hB0, 4'b1101);

        // Live update: edges sample counts 9..12, so the last one is back in the score-2 phase
        repeat (4) edge_sample();
        chk_both("live_pre", 8'h99, 4'b0111);
        @(negedge clock);
        scor2 = 4'd5;
        #1;
        chk("live_hold.out", out, 8'h99);
        edge_sample();
        $display("txn live_update out=%h dec=%b", out, dec);
        chk_both("live_update", 8'h92, 4'b0111);

        // Reset mid-display (count is 14, score-2 phase): outputs blank immediately
        #2;
        reset = 1'b1;
        #1;
        $display("txn mid_reset out=%h dec=%b", out, dec);
        chk_both("mid_reset", 8'hFF, 4'b1111);
        edge_sample();
        chk_both("mid_reset_edge", 8'hFF, 4'b1111);
        @(negedge clock);
        reset = 1'b0;
        edge_sample();
        $display("txn post_reset out=%h dec=%b", out, dec);
        chk_both("post_reset", 8'hB0, 4'b1101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
